// File: rtl/machine_timer.sv
// RISC-V machine timer: mtime/mtimecmp with prescaler, on the data-memory port.
// Produces a level machine timer interrupt when mtime >= mtimecmp.
module machine_timer #(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [63:0] MTIME_RST  = 64'h0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sel_i,
    input  logic [31:0] addr_i,
    input  logic        read_i,
    output logic [31:0] rdata_o,
    input  logic [3:0]  wsel_byte_i,
    input  logic [31:0] wdata_i,
    output logic        timer_irq_o
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned AW = 3;

    localparam logic [AW-1:0] OFF_MTIME_LO = AW'(0);
    localparam logic [AW-1:0] OFF_MTIME_HI = AW'(1);
    localparam logic [AW-1:0] OFF_CMP_LO   = AW'(2);
    localparam logic [AW-1:0] OFF_CMP_HI   = AW'(3);
    localparam logic [AW-1:0] OFF_CTRL     = AW'(4);
    localparam logic [AW-1:0] OFF_PRESCALE = AW'(5);

    logic [TW-1:0]         mtime_q,    mtime_d;
    logic [TW-1:0]         mtimecmp_q, mtimecmp_d;
    logic                  en_q,       en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pc_q,       pc_d;
    logic [DW-1:0]         rdata_q,    rdata_d;
    logic                  irq_q;

    logic          wr, rd, tick;
    logic [AW-1:0] idx;
    logic          wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl, wr_pre;
    logic          unused_addr;

    // Replace only the byte lanes selected by be.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old,
                                                   input logic [DW-1:0] wd,
                                                   input logic [3:0]    be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    // Access decode and prescaler tick.
    always_comb begin
        idx     = addr_i[4:2];
        wr      = sel_i && (wsel_byte_i != 4'b0000);
        rd      = sel_i && read_i;
        wr_mlo  = wr && (idx == OFF_MTIME_LO);
        wr_mhi  = wr && (idx == OFF_MTIME_HI);
        wr_clo  = wr && (idx == OFF_CMP_LO);
        wr_chi  = wr && (idx == OFF_CMP_HI);
        wr_ctrl = wr && (idx == OFF_CTRL);
        wr_pre  = wr && (idx == OFF_PRESCALE);
        tick    = en_q && (pc_q == prescale_q);
    end

    // Next-state: a software write to either mtime word suppresses that cycle's increment.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        pc_d       = pc_q;
        rdata_d    = rdata_q;

        if (wr_mlo || wr_mhi) begin
            if (wr_mlo) mtime_d[31:0]  = merge_bytes(mtime_q[31:0],  wdata_i, wsel_byte_i);
            if (wr_mhi) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, wsel_byte_i);
        end else if (tick) begin
            mtime_d = mtime_q + TW'(1);
        end

        if (wr_clo) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  wdata_i, wsel_byte_i);
        if (wr_chi) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, wsel_byte_i);

        if (wr_ctrl && wsel_byte_i[0]) en_d = wdata_i[0];
        if (wr_pre) begin
            prescale_d = PRESCALE_W'(merge_bytes(DW'(prescale_q), wdata_i, wsel_byte_i));
        end

        if (wr_ctrl || wr_pre || tick) begin
            pc_d = '0;
        end else if (en_q) begin
            pc_d = pc_q + PRESCALE_W'(1);
        end

        if (rd) begin
            unique case (idx)
                OFF_MTIME_LO: rdata_d = mtime_q[31:0];
                OFF_MTIME_HI: rdata_d = mtime_q[63:32];
                OFF_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                OFF_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                OFF_CTRL:     rdata_d = DW'(en_q);
                OFF_PRESCALE: rdata_d = DW'(prescale_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mtime_q    <= MTIME_RST;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            prescale_q <= '0;
            pc_q       <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pc_q       <= pc_d;
            rdata_q    <= rdata_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign rdata_o     = rdata_q;
    assign timer_irq_o = irq_q;

endmodule

// File: doc/machine_timer.md
Name: machine_timer

Overview:
- RISC-V machine timer peripheral (mtime/mtimecmp) on the core's data-memory port, downstream of the MEM stage.
- Sits behind the top-level address decoder, alongside data memory. Same read/write signalling as the data memory.
- Produces the machine timer interrupt request for the CS register file / controller.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescale counter (1..32).
- MTIME_RST, 64'h0, reset value of mtime.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  synchronous active-low reset
- sel_i  in  1  address decoder hit; qualifies read_i and wsel_byte_i
- addr_i  in  32  byte address; only addr_i[4:2] decoded, addr_i[1:0] ignored
- read_i  in  1  read strobe
- rdata_o  out  32  read data, valid the cycle after the read strobe
- wsel_byte_i  in  4  byte write enables; bit n writes wdata_i[8n+7:8n]
- wdata_i  in  32  write data
- timer_irq_o  out  1  machine timer interrupt pending, level

Behaviour:
- Register map (word offsets, addr_i[4:2]):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 EN, other bits read 0 and ignore writes
  - 5 PRESCALE: [PRESCALE_W-1:0] R/W, upper bits read 0
  - 6,7 unmapped: read 0, writes ignored
- Reset values, all synchronous on rstn_i low:
  - mtime = MTIME_RST
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - EN = 0, PRESCALE = 0, prescale counter = 0
  - rdata_o = 0, timer_irq_o = 0
- Access qualification:
  - Write occurs when sel_i=1 and wsel_byte_i != 0. Byte lanes are independent; partial writes update only the selected bytes.
  - Read occurs when sel_i=1 and read_i=1.
- Read timing:
  - rdata_o is registered and presents the register value sampled at the read cycle (pre-write value if the same register is written that cycle).
  - On cycles without a read, rdata_o holds its previous value.
- Prescaler:
  - Counter pc runs only while EN=1.
  - tick = EN && (pc == PRESCALE).
  - On tick, pc <= 0. Otherwise, while EN=1, pc <= pc+1.
  - EN=0 freezes pc and mtime.
  - Any write to PRESCALE or to CTRL clears pc to 0 in that cycle.
  - PRESCALE=0 gives one tick per cycle.
- mtime increment:
  - On tick, mtime <= mtime + 1, 64-bit with carry from LO into HI.
  - Wraps FFFF_FFFF_FFFF_FFFF -> 0 silently.
- mtime write vs tick in the same cycle:
  - The software write wins for the written word.
  - The increment for that cycle is dropped entirely; no carry into the unwritten word.
- mtimecmp: written only by software; no side effects other than the interrupt compare.
- Interrupt:
  - Next-cycle timer_irq_o = (mtime_q >= mtimecmp_q), unsigned 64-bit compare on current register values.
  - Latency is one cycle after the condition becomes true in registers, so two cycles after the write or tick that causes it.
  - Level-sensitive: deasserts only when software raises mtimecmp or lowers mtime, with the same latency.
  - Not gated by EN.
- Reset mid-operation: all state returns to reset values on the next edge; an in-flight read returns 0.
- Single clock domain; no handshake back-pressure; every access completes in one cycle.

Test Plan:
- Reset with rstn_i low 2 cycles, then read offsets 0..5 -> rdata_o = 0,0,FFFF_FFFF,FFFF_FFFF,0,0; timer_irq_o = 0.
- Write PRESCALE=0, CTRL=1, wait 10 cycles, read MTIME_LO -> 10 ±1 per the documented write-to-count latency (bench computes exact); PRESCALE=3 -> mtime increments once every 4 cycles.
- Write MTIME_LO=FFFF_FFFF, MTIME_HI=0, EN=1, PRESCALE=0 -> after one tick MTIME_HI=1, MTIME_LO=0; from mtime=all-ones -> wraps to 0.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20 with mtime counting from 0 -> timer_irq_o rises exactly 1 cycle after mtime reaches 20; write MTIMECMP_LO=FFFF_FFFF -> irq falls 2 cycles after the write.
- Byte write to MTIMECMP_LO with wsel_byte_i=4'b0010, wdata_i=32'h0000_AB00 over FFFF_FFFF -> reads FFFF_ABFF.
- EN=1, PRESCALE=0, write MTIME_LO=5 in a tick cycle -> next read returns 5, then 6 the following cycle; sel_i=0 with wsel_byte_i=F -> no register changes.
